// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares one single-ported data memory between two requesters (port 0 and
// port 1). Grants are combinational so the winning access is issued in the
// same cycle; load data comes back from memory one cycle later and is routed
// to the port that issued the load.
//
// Ports
//   clk, rst                         clock, asynchronous active-high reset
//   pN_req/we/be/funct3/addr/wdata   request and payload from port N (0/1)
//   pN_gnt                           combinational grant to port N
//   pN_rvalid, pN_rdata              registered load-valid strobe and data
//   p1_err                           one-cycle pulse: port-1 MMIO store dropped
//   MemWrite, be, funct3, Address,
//   WriteData                        memory command for the granted access
//   ReadData                         memory read data, one cycle after command
//
// FIXED_PRIO=0 alternates between ports under contention. FIXED_PRIO=1
// prefers port 0 but forces port 1 through once it has been refused MAX_WAIT
// consecutive cycles.
module mem_port_arbiter #(
  parameter int FIXED_PRIO = 0,
  parameter int MAX_WAIT   = 4,
  parameter int ALEN       = 32,
  parameter int XLEN       = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            p0_req,
  input  logic            p0_we,
  input  logic [3:0]      p0_be,
  input  logic [2:0]      p0_funct3,
  input  logic [ALEN-1:0] p0_addr,
  input  logic [XLEN-1:0] p0_wdata,
  output logic            p0_gnt,
  output logic            p0_rvalid,
  output logic [XLEN-1:0] p0_rdata,
  input  logic            p1_req,
  input  logic            p1_we,
  input  logic [3:0]      p1_be,
  input  logic [2:0]      p1_funct3,
  input  logic [ALEN-1:0] p1_addr,
  input  logic [XLEN-1:0] p1_wdata,
  output logic            p1_gnt,
  output logic            p1_rvalid,
  output logic [XLEN-1:0] p1_rdata,
  output logic            p1_err,
  output logic            MemWrite,
  output logic [3:0]      be,
  output logic [2:0]      funct3,
  output logic [ALEN-1:0] Address,
  output logic [XLEN-1:0] WriteData,
  input  logic [XLEN-1:0] ReadData
);

  localparam int WW = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
  localparam logic [WW-1:0] WAIT_MAX = WW'(MAX_WAIT);

  logic          prio_r;       // 0: port 0 wins the next tie, 1: port 1
  logic [WW-1:0] wait_cnt_r;   // consecutive cycles port 1 was refused
  logic          rd_pend_r;    // a load was issued last cycle
  logic          rd_owner_r;   // port that issued that load
  logic          pick_p1_s;
  logic          load_gnt_s;
  logic          mmio_drop_s;

  // Grant selection; grants are forced low while reset is asserted.
  always_comb begin
    p0_gnt    = 1'b0;
    p1_gnt    = 1'b0;
    pick_p1_s = 1'b0;
    if (FIXED_PRIO != 0) begin
      pick_p1_s = (wait_cnt_r == WAIT_MAX);
    end else begin
      pick_p1_s = prio_r;
    end
    if (rst) begin
      p0_gnt = 1'b0;
      p1_gnt = 1'b0;
    end else if (p0_req && p1_req) begin
      p0_gnt = !pick_p1_s;
      p1_gnt = pick_p1_s;
    end else begin
      p0_gnt = p0_req;
      p1_gnt = p1_req;
    end
  end

  // Memory command mux; port-1 stores into the MMIO half (addr MSB set) are
  // issued with the write enable suppressed so the access still completes.
  always_comb begin
    MemWrite    = 1'b0;
    be          = 4'b0000;
    funct3      = 3'b000;
    Address     = {ALEN{1'b0}};
    WriteData   = {XLEN{1'b0}};
    load_gnt_s  = (p0_gnt && !p0_we) || (p1_gnt && !p1_we);
    mmio_drop_s = p1_gnt && p1_we && p1_addr[ALEN-1];
    case ({p1_gnt, p0_gnt})
      2'b01: begin
        MemWrite  = p0_we;
        be        = p0_be;
        funct3    = p0_funct3;
        Address   = p0_addr;
        WriteData = p0_wdata;
      end
      2'b10: begin
        MemWrite  = p1_we && !p1_addr[ALEN-1];
        be        = p1_be;
        funct3    = p1_funct3;
        Address   = p1_addr;
        WriteData = p1_wdata;
      end
      default: begin
        MemWrite  = 1'b0;
        be        = 4'b0000;
        funct3    = 3'b000;
        Address   = {ALEN{1'b0}};
        WriteData = {XLEN{1'b0}};
      end
    endcase
  end

  // Arbitration state: round-robin pointer and port-1 starvation counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prio_r     <= 1'b0;
      wait_cnt_r <= {WW{1'b0}};
    end else begin
      if (p0_gnt) begin
        prio_r <= 1'b1;
      end else if (p1_gnt) begin
        prio_r <= 1'b0;
      end else begin
        prio_r <= prio_r;
      end
      if (p1_gnt) begin
        wait_cnt_r <= {WW{1'b0}};
      end else if (p1_req && (wait_cnt_r != WAIT_MAX)) begin
        wait_cnt_r <= wait_cnt_r + WW'(1);
      end else begin
        wait_cnt_r <= wait_cnt_r;
      end
    end
  end

  // Load response tracking and the registered per-port strobes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_pend_r  <= 1'b0;
      rd_owner_r <= 1'b0;
      p0_rvalid  <= 1'b0;
      p1_rvalid  <= 1'b0;
      p1_err     <= 1'b0;
    end else begin
      rd_pend_r <= load_gnt_s;
      if (load_gnt_s) begin
        rd_owner_r <= p1_gnt;
      end else begin
        rd_owner_r <= rd_owner_r;
      end
      p0_rvalid <= p0_gnt && !p0_we;
      p1_rvalid <= p1_gnt && !p1_we;
      p1_err    <= mmio_drop_s;
    end
  end

  // Route returning read data to the owning port only; the other sees zero.
  always_comb begin
    p0_rdata = {XLEN{1'b0}};
    p1_rdata = {XLEN{1'b0}};
    if (rd_pend_r && !rd_owner_r) begin
      p0_rdata = ReadData;
    end else if (rd_pend_r && rd_owner_r) begin
      p1_rdata = ReadData;
    end else begin
      p0_rdata = {XLEN{1'b0}};
      p1_rdata = {XLEN{1'b0}};
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter
// Directed bench for mem_port_arbiter. Instance dut uses round-robin
// arbitration and drives a small word memory with an LED register at
// 0x80000000; instance dut1 uses fixed priority with MAX_WAIT=4 and shares
// the same request inputs. Inputs change #1 after posedge, outputs are
// checked on the negedge.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        p0_req = 1'b0, p0_we = 1'b0, p1_req = 1'b0, p1_we = 1'b0;
  logic [3:0]  p0_be = 4'h0, p1_be = 4'h0;
  logic [2:0]  p0_funct3 = 3'd0, p1_funct3 = 3'd0;
  logic [31:0] p0_addr = 32'h0, p1_addr = 32'h0, p0_wdata = 32'h0, p1_wdata = 32'h0;
  logic [31:0] ReadData = 32'h0;

  logic        p0_gnt, p1_gnt, p0_rvalid, p1_rvalid, p1_err, MemWrite;
  logic [31:0] p0_rdata, p1_rdata, Address, WriteData;
  logic [3:0]  be;
  logic [2:0]  funct3;

  logic        d1_p0_gnt, d1_p1_gnt, d1_p0_rvalid, d1_p1_rvalid, d1_p1_err, d1_MemWrite;
  logic [31:0] d1_p0_rdata, d1_p1_rdata, d1_Address, d1_WriteData;
  logic [3:0]  d1_be;
  logic [2:0]  d1_funct3;

  logic [31:0] mem [0:255];
  logic [31:0] led_r;

  int tests_run = 0;
  int fail_cnt  = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.FIXED_PRIO(0), .MAX_WAIT(4), .ALEN(32), .XLEN(32)) dut (
    .clk(clk), .rst(rst),
    .p0_req(p0_req), .p0_we(p0_we), .p0_be(p0_be), .p0_funct3(p0_funct3),
    .p0_addr(p0_addr), .p0_wdata(p0_wdata), .p0_gnt(p0_gnt),
    .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata),
    .p1_req(p1_req), .p1_we(p1_we), .p1_be(p1_be), .p1_funct3(p1_funct3),
    .p1_addr(p1_addr), .p1_wdata(p1_wdata), .p1_gnt(p1_gnt),
    .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata), .p1_err(p1_err),
    .MemWrite(MemWrite), .be(be), .funct3(funct3), .Address(Address),
    .WriteData(WriteData), .ReadData(ReadData)
  );

  mem_port_arbiter #(.FIXED_PRIO(1), .MAX_WAIT(4), .ALEN(32), .XLEN(32)) dut1 (
    .clk(clk), .rst(rst),
    .p0_req(p0_req), .p0_we(p0_we), .p0_be(p0_be), .p0_funct3(p0_funct3),
    .p0_addr(p0_addr), .p0_wdata(p0_wdata), .p0_gnt(d1_p0_gnt),
    .p0_rvalid(d1_p0_rvalid), .p0_rdata(d1_p0_rdata),
    .p1_req(p1_req), .p1_we(p1_we), .p1_be(p1_be), .p1_funct3(p1_funct3),
    .p1_addr(p1_addr), .p1_wdata(p1_wdata), .p1_gnt(d1_p1_gnt),
    .p1_rvalid(d1_p1_rvalid), .p1_rdata(d1_p1_rdata), .p1_err(d1_p1_err),
    .MemWrite(d1_MemWrite), .be(d1_be), .funct3(d1_funct3), .Address(d1_Address),
    .WriteData(d1_WriteData), .ReadData(ReadData)
  );

  // Memory model: word array preloaded with 0xA5000000|index on reset,
  // LED register at 0x80000000, read data one cycle after the command.
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 256; i++) mem[i] <= 32'hA500_0000 | 32'(i);
      led_r <= 32'h0;
    end else if (MemWrite) begin
      if (Address[31]) begin
        if (Address == 32'h8000_0000) led_r <= WriteData;
      end else begin
        mem[Address[9:2]] <= WriteData;
      end
    end
    ReadData <= mem[Address[9:2]];
  end

  task automatic idle_inputs();
    p0_req = 1'b0; p0_we = 1'b0; p0_be = 4'h0; p0_funct3 = 3'd0; p0_addr = 32'h0; p0_wdata = 32'h0;
    p1_req = 1'b0; p1_we = 1'b0; p1_be = 4'h0; p1_funct3 = 3'd0; p1_addr = 32'h0; p1_wdata = 32'h0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    p0_req = 1'b1; p1_req = 1'b1;
    @(negedge clk);
    tests_run++; if (p0_gnt !== 1'b0 || p1_gnt !== 1'b0) begin fail_cnt++; $display("FAIL rst_gnt_gated: got %b%b want 00", p1_gnt, p0_gnt); end
    tests_run++; if (p0_rvalid !== 1'b0 || p1_rvalid !== 1'b0 || p1_err !== 1'b0) begin fail_cnt++; $display("FAIL rst_strobes: got rv=%b%b err=%b want 0", p1_rvalid, p0_rvalid, p1_err); end
    tests_run++; if (MemWrite !== 1'b0 || Address !== 32'h0) begin fail_cnt++; $display("FAIL rst_cmd_idle: got we=%b addr=%h want 0", MemWrite, Address); end
    tests_run++; if (dut1.wait_cnt_r !== 3'd0) begin fail_cnt++; $display("FAIL rst_wait_cnt: got %0d want 0", dut1.wait_cnt_r); end
    idle_inputs();
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    tests_run++; if (p0_gnt !== 1'b0 || p1_gnt !== 1'b0 || MemWrite !== 1'b0) begin fail_cnt++; $display("FAIL idle_no_gnt: got %b%b we=%b want 000", p1_gnt, p0_gnt, MemWrite); end
  endtask

  task automatic test_round_robin();
    int exp_g, prev_g;
    logic [31:0] exp_data;
    do_reset();
    p0_req = 1'b1; p0_addr = 32'h10;
    p1_req = 1'b1; p1_addr = 32'h20;
    prev_g = -1;
    exp_data = 32'h0;
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      if (prev_g == 0) begin
        tests_run++; if (p0_rvalid !== 1'b1 || p0_rdata !== exp_data || p1_rvalid !== 1'b0 || p1_rdata !== 32'h0) begin fail_cnt++; $display("FAIL rr_resp_p0[%0d]: got rv=%b%b d0=%h d1=%h want rv=01 d0=%h d1=0", k, p1_rvalid, p0_rvalid, p0_rdata, p1_rdata, exp_data); end
      end else if (prev_g == 1) begin
        tests_run++; if (p1_rvalid !== 1'b1 || p1_rdata !== exp_data || p0_rvalid !== 1'b0 || p0_rdata !== 32'h0) begin fail_cnt++; $display("FAIL rr_resp_p1[%0d]: got rv=%b%b d1=%h d0=%h want rv=10 d1=%h d0=0", k, p1_rvalid, p0_rvalid, p1_rdata, p0_rdata, exp_data); end
      end else if (k == 6) begin
        tests_run++; if (p0_rvalid !== 1'b0 || p1_rvalid !== 1'b0) begin fail_cnt++; $display("FAIL rr_no_extra_rvalid: got %b%b want 00", p1_rvalid, p0_rvalid); end
      end
      if (k < 6) begin
        exp_g = k % 2;
        tests_run++; if (p0_gnt !== (exp_g == 0) || p1_gnt !== (exp_g == 1)) begin fail_cnt++; $display("FAIL rr_gnt[%0d]: got %b%b want p%0d", k, p1_gnt, p0_gnt, exp_g); end
        tests_run++; if (Address !== ((exp_g == 0) ? p0_addr : p1_addr) || MemWrite !== 1'b0) begin fail_cnt++; $display("FAIL rr_addr[%0d]: got %h we=%b", k, Address, MemWrite); end
        @(posedge clk); #1;
        if (exp_g == 0) begin
          exp_data = 32'hA500_0000 | (p0_addr >> 2);
          p0_addr = p0_addr + 32'h4;
        end else begin
          exp_data = 32'hA500_0000 | (p1_addr >> 2);
          p1_addr = p1_addr + 32'h4;
        end
        prev_g = exp_g;
        if (k == 5) idle_inputs();
      end else begin
        prev_g = -1;
      end
    end
  endtask

  task automatic test_fixed_prio();
    int exp_g, prev_g, exp_w;
    do_reset();
    p0_req = 1'b1; p0_addr = 32'h10;
    p1_req = 1'b1; p1_addr = 32'h20;
    prev_g = -1;
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      exp_g = (k == 4) ? 1 : 0;
      exp_w = (k <= 4) ? k : k - 5;
      tests_run++; if (d1_p0_gnt !== (exp_g == 0) || d1_p1_gnt !== (exp_g == 1)) begin fail_cnt++; $display("FAIL fp_gnt[%0d]: got %b%b want p%0d", k, d1_p1_gnt, d1_p0_gnt, exp_g); end
      tests_run++; if (dut1.wait_cnt_r !== 3'(exp_w)) begin fail_cnt++; $display("FAIL fp_wait_cnt[%0d]: got %0d want %0d", k, dut1.wait_cnt_r, exp_w); end
      tests_run++; if (d1_Address !== ((exp_g == 0) ? 32'h10 : 32'h20) || d1_MemWrite !== 1'b0 || d1_p1_err !== 1'b0) begin fail_cnt++; $display("FAIL fp_cmd[%0d]: got addr=%h we=%b err=%b", k, d1_Address, d1_MemWrite, d1_p1_err); end
      if (prev_g >= 0) begin
        tests_run++; if (d1_p0_rvalid !== (prev_g == 0) || d1_p1_rvalid !== (prev_g == 1)) begin fail_cnt++; $display("FAIL fp_rvalid[%0d]: got %b%b want p%0d", k, d1_p1_rvalid, d1_p0_rvalid, prev_g); end
      end
      @(posedge clk); #1;
      prev_g = exp_g;
    end
    idle_inputs();
  endtask

  task automatic test_mmio();
    do_reset();
    p1_req = 1'b1; p1_we = 1'b1; p1_be = 4'hF; p1_funct3 = 3'd2; p1_addr = 32'h8000_0000; p1_wdata = 32'hF;
    @(negedge clk);
    tests_run++; if (p1_gnt !== 1'b1 || MemWrite !== 1'b0 || p1_err !== 1'b0) begin fail_cnt++; $display("FAIL mmio_p1_issue: got gnt=%b we=%b err=%b want 1 0 0", p1_gnt, MemWrite, p1_err); end
    @(posedge clk); #1;
    idle_inputs();
    @(negedge clk);
    tests_run++; if (p1_err !== 1'b1 || p1_rvalid !== 1'b0 || led_r !== 32'h0) begin fail_cnt++; $display("FAIL mmio_p1_err: got err=%b rv=%b led=%h want 1 0 0", p1_err, p1_rvalid, led_r); end
    @(posedge clk); #1;
    p0_req = 1'b1; p0_we = 1'b1; p0_be = 4'hF; p0_funct3 = 3'd2; p0_addr = 32'h8000_0000; p0_wdata = 32'hF;
    @(negedge clk);
    tests_run++; if (p1_err !== 1'b0) begin fail_cnt++; $display("FAIL mmio_err_one_cycle: got %b want 0", p1_err); end
    tests_run++; if (p0_gnt !== 1'b1 || MemWrite !== 1'b1 || Address !== 32'h8000_0000 || WriteData !== 32'hF || be !== 4'hF || funct3 !== 3'd2) begin fail_cnt++; $display("FAIL mmio_p0_pass: got gnt=%b we=%b addr=%h wd=%h be=%h f3=%0d", p0_gnt, MemWrite, Address, WriteData, be, funct3); end
    @(posedge clk); #1;
    idle_inputs();
    @(negedge clk);
    tests_run++; if (led_r !== 32'hF || p1_err !== 1'b0 || p0_rvalid !== 1'b0) begin fail_cnt++; $display("FAIL mmio_p0_led: got led=%h err=%b rv=%b want F 0 0", led_r, p1_err, p0_rvalid); end
  endtask

  task automatic test_reset_drop();
    do_reset();
    p0_req = 1'b1; p0_addr = 32'h100;
    @(negedge clk);
    tests_run++; if (p0_gnt !== 1'b1) begin fail_cnt++; $display("FAIL rd_drop_gnt: got %b want 1", p0_gnt); end
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    tests_run++; if (p0_rvalid !== 1'b0 || p0_gnt !== 1'b0) begin fail_cnt++; $display("FAIL rd_drop_in_rst: got rv=%b gnt=%b want 0 0", p0_rvalid, p0_gnt); end
    @(posedge clk); #1;
    rst = 1'b0;
    idle_inputs();
    @(negedge clk);
    tests_run++; if (p0_rvalid !== 1'b0 || p1_rvalid !== 1'b0) begin fail_cnt++; $display("FAIL rd_drop_after: got %b%b want 00", p1_rvalid, p0_rvalid); end
    @(posedge clk); #1;
    p1_req = 1'b1; p1_addr = 32'h104;
    @(negedge clk);
    tests_run++; if (p1_gnt !== 1'b1 || p0_gnt !== 1'b0) begin fail_cnt++; $display("FAIL rd_p1_gnt: got %b%b want 10", p1_gnt, p0_gnt); end
    @(posedge clk); #1;
    idle_inputs();
    @(negedge clk);
    tests_run++; if (p1_rvalid !== 1'b1 || p1_rdata !== 32'hA500_0041 || p0_rvalid !== 1'b0 || p0_rdata !== 32'h0) begin fail_cnt++; $display("FAIL rd_p1_resp: got rv=%b%b d1=%h d0=%h want 10 A5000041 0", p1_rvalid, p0_rvalid, p1_rdata, p0_rdata); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    p0_req = 1'b1; p0_we = 1'b1; p0_be = 4'hF; p0_funct3 = 3'd2; p0_addr = 32'h40; p0_wdata = 32'hDEAD_BEEF;
    p1_req = 1'b1; p1_we = 1'b0; p1_be = 4'hF; p1_funct3 = 3'd2; p1_addr = 32'h40;
    @(negedge clk);
    tests_run++; if (p0_gnt !== 1'b1 || p1_gnt !== 1'b0 || MemWrite !== 1'b1 || WriteData !== 32'hDEAD_BEEF) begin fail_cnt++; $display("FAIL b2b_store: got gnt=%b%b we=%b wd=%h", p1_gnt, p0_gnt, MemWrite, WriteData); end
    @(posedge clk); #1;
    p0_req = 1'b0; p0_we = 1'b0;
    @(negedge clk);
    tests_run++; if (p1_gnt !== 1'b1 || MemWrite !== 1'b0 || p0_rvalid !== 1'b0) begin fail_cnt++; $display("FAIL b2b_load: got gnt=%b we=%b rv0=%b want 1 0 0", p1_gnt, MemWrite, p0_rvalid); end
    @(posedge clk); #1;
    idle_inputs();
    @(negedge clk);
    tests_run++; if (p1_rvalid !== 1'b1 || p1_rdata !== 32'hDEAD_BEEF || p0_rvalid !== 1'b0) begin fail_cnt++; $display("FAIL b2b_resp: got rv=%b%b d1=%h want 10 DEADBEEF", p1_rvalid, p0_rvalid, p1_rdata); end
    @(posedge clk); #1;
    @(negedge clk);
    tests_run++; if (p1_rvalid !== 1'b0 || p0_rvalid !== 1'b0 || p1_rdata !== 32'h0) begin fail_cnt++; $display("FAIL b2b_single_pulse: got rv=%b%b d1=%h want 00 0", p1_rvalid, p0_rvalid, p1_rdata); end
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_fixed_prio();
    test_mmio();
    test_reset_drop();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, fail_cnt);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter FIXED_PRIO, default 0: 0 = round-robin between ports; 1 = port 0 preferred, subject to the starvation guard.
REQ-002 Parameter MAX_WAIT, default 4: cycles port 1 may be refused in FIXED_PRIO=1 mode before it is forced.
REQ-003 clk  input  1  sole clock; all state on posedge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 p0_req, p1_req  input  1 each  access request, held with its payload until granted.
REQ-006 p0_we, p1_we  input  1 each  1 = store, 0 = load.
REQ-007 p0_be, p1_be  input  4 each  byte enables.
REQ-008 p0_funct3, p1_funct3  input  3 each  load/store type.
REQ-009 p0_addr, p1_addr  input  ALEN each  byte address.
REQ-010 p0_wdata, p1_wdata  input  XLEN each  store data.
REQ-011 p0_gnt, p1_gnt  output  1 each  combinational grant; the access is issued this cycle.
REQ-012 p0_rvalid, p1_rvalid  output  1 each  registered load-data-valid strobe.
REQ-013 p0_rdata, p1_rdata  output  XLEN each  load data, valid only with rvalid.
REQ-014 p1_err  output  1  registered one-cycle pulse: a port-1 store to the MMIO region was dropped.
REQ-015 MemWrite  output  1  memory write enable.
REQ-016 be, funct3, Address, WriteData  output  4/3/ALEN/XLEN  memory command fields.
REQ-017 ReadData  input  XLEN  memory read data, one cycle after the command.

Function
REQ-018 At most one of p0_gnt and p1_gnt SHALL be high in any cycle, and a gnt SHALL be high only when its req is high.
REQ-019 With a single requester, that requester SHALL be granted in the same cycle.
REQ-020 With both requesting and FIXED_PRIO=0, the port indicated by the prio register SHALL be granted; on every grant, prio SHALL be set to the other port.
REQ-021 With both requesting and FIXED_PRIO=1, port 0 SHALL be granted unless wait_cnt==MAX_WAIT, in which case port 1 SHALL be granted.
REQ-022 wait_cnt SHALL increment each cycle p1_req && !p1_gnt, saturate at MAX_WAIT, clear on p1_gnt, and have width clog2(MAX_WAIT+1).
REQ-023 The memory command fields SHALL be copied from the granted port; with no grant they SHALL be driven to zero with MemWrite=0.
REQ-024 MemWrite SHALL equal gnt && we, except that a port-1 store with addr[ALEN-1]==1 SHALL be granted with MemWrite=0, and p1_err SHALL pulse on the following cycle.
REQ-025 Port-0 MMIO stores (LED 0x80000000, tohost 0x80001000) SHALL pass through unmodified.
REQ-026 A granted load SHALL set rd_pend=1 and rd_owner=the granted port; in the next cycle, rd_owner's rvalid SHALL be 1 and its rdata SHALL equal ReadData.
REQ-027 rvalid SHALL be high for exactly one cycle per granted load, and never for stores.
REQ-028 Back-to-back loads, including alternating ports, SHALL each return one cycle after their grant, sustaining one access per cycle.
REQ-029 The rdata of a non-owning port SHALL be driven to zero.
REQ-030 Requesters SHALL hold their payload stable while req is high and not granted; after a grant, a requester may present a new request in the next cycle.

Reset
REQ-031 While rst is high, asynchronously: prio=0 (port 0 preferred), wait_cnt=0, rd_pend=0, rd_owner=0, both rvalid=0, p1_err=0.
REQ-032 Reset asserted with a load outstanding SHALL drop that response: no rvalid SHALL follow.
REQ-033 Grants remain combinational during reset but SHALL be gated to 0 while rst is high.

Verification
REQ-034 FIXED_PRIO=0, both ports issue continuous loads for 6 cycles after reset -> grants alternate p0,p1,p0,p1,p0,p1; each rvalid follows its grant by 1 cycle with that port's data.
REQ-035 FIXED_PRIO=1, MAX_WAIT=4, both requesting continuously -> grants p0,p0,p0,p0,p1,p0,...; wait_cnt reads 4 in the p1-grant cycle and 0 in the next.
REQ-036 p1 store to 0x80000000, data 0xF -> p1_gnt=1, MemWrite=0, p1_err pulses for one cycle, LEDs unchanged; the same store from p0 -> MemWrite=1.
REQ-037 p0 load of 0x100 granted, rst asserted in the next cycle -> p0_rvalid stays 0; after release, a p1 load of 0x104 returns on p1 only.
REQ-038 p0 SW 0xDEADBEEF to 0x40 granted in cycle n, p1 LW 0x40 granted in cycle n+1 -> p1_rvalid in cycle n+2 with rdata 0xDEADBEEF; p0_rvalid never asserted.
